input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have a parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on din (minimum 2).
REQ-002 The block SHALL have a parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable synchronized cycles required to accept a new level (minimum 2).
REQ-003 The block SHALL have a parameter CNT_WIDTH, default 8, giving the width of the rise-event counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-006 The block SHALL have port din, input, 1 bit: the raw asynchronous level, which may glitch.
REQ-007 The block SHALL have port clr_count, input, 1 bit: a synchronous clear of rise_count and cnt_sat.
REQ-008 The block SHALL have port level, output, 1 bit: the registered debounced level that feeds downstream combinational logic.
REQ-009 The block SHALL have port rise, output, 1 bit: a one-cycle pulse when level goes 0->1.
REQ-010 The block SHALL have port fall, output, 1 bit: a one-cycle pulse when level goes 1->0.
REQ-011 The block SHALL have port rise_count, output, CNT_WIDTH bits: the count of accepted rise events.
REQ-012 The block SHALL have port cnt_sat, output, 1 bit: a sticky flag set when rise_count has saturated.

Function
REQ-013 din SHALL pass through SYNC_STAGES flops, giving din_s; only din_s is used by the FSM.
REQ-014 The FSM SHALL have exactly the states LOW_STABLE, WAIT_HIGH, HIGH_STABLE and WAIT_LOW.
REQ-015 In LOW_STABLE with din_s=1, the FSM SHALL go to WAIT_HIGH with stable_cnt=1; otherwise it SHALL hold.
REQ-016 In WAIT_HIGH: din_s=0 SHALL return to LOW_STABLE and clear stable_cnt; stable_cnt=DEBOUNCE_CYCLES-1 with din_s=1 SHALL go to HIGH_STABLE, set level=1 and pulse rise; otherwise stable_cnt SHALL increment.
REQ-017 HIGH_STABLE and WAIT_LOW SHALL mirror REQ-015/016 with polarity inverted, pulsing fall and clearing level.
REQ-018 Latency from the first clock edge that samples din stable at the new value to the level change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES edges (6 at defaults).
REQ-019 rise and fall SHALL be registered, high for exactly one cycle, never high together, and coincident with the cycle level first shows the new value.
REQ-020 Any din_s excursion shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on level, rise or fall.
REQ-021 rise_count SHALL increment by 1 in the cycle after each rise pulse and saturate at all-ones without wrap-around.
REQ-022 cnt_sat SHALL set in the cycle rise_count reaches all-ones and remain set until clr_count or rst.
REQ-023 clr_count SHALL zero rise_count and cnt_sat on the next edge and take precedence over a coincident increment, so that increment is lost.
REQ-024 clr_count SHALL NOT affect the FSM, level, rise or fall.

Reset
REQ-025 rst SHALL force, on the next clk edge: sync flops 0, state LOW_STABLE, stable_cnt 0, level 0, rise 0, fall 0, rise_count 0, cnt_sat 0.
REQ-026 rst asserted mid-WAIT_HIGH or mid-WAIT_LOW SHALL abandon the qualification with no pulse; after release, qualification SHALL restart from the synchronizer.
REQ-027 rst SHALL take precedence over clr_count and all FSM transitions.

Structure
REQ-028 The package input_debouncer_pkg SHALL hold the FSM state enum typedef and the parameter default constants.
REQ-029 The synchronizer SHALL be a sub-module sync_chain, parameterised by stage count, with ports clk, rst, d and q.
REQ-030 The stable_cnt width SHALL be $clog2(DEBOUNCE_CYCLES), with at least 1 bit.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated)
REQ-031 Scenario: rst for 2 cycles with din=0 -> level=0, rise=0, fall=0, rise_count=0, cnt_sat=0.
REQ-032 Scenario: din 0->1 and held -> level=1 and rise=1 for one cycle on the 6th sampling edge; rise_count=1 one cycle later.
REQ-033 Scenario: din high for 3 cycles then low -> level stays 0, no rise, rise_count=0.
REQ-034 Scenario: CNT_WIDTH=2, five clean 0->1->0 cycles -> rise_count=3 and cnt_sat=1 after the third; then clr_count -> both 0 next cycle.
REQ-035 Scenario: rst asserted during WAIT_HIGH and released with din high -> no rise before a full 6-edge requalification; level then rises.
REQ-036 Scenario: clr_count in the same cycle as rise -> rise pulses, level=1, and rise_count=0 afterwards.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared types and parameter defaults for the input debouncer.
package input_debouncer_pkg;

  localparam int unsigned SyncStagesDefault     = 2;
  localparam int unsigned DebounceCyclesDefault = 4;
  localparam int unsigned CntWidthDefault       = 8;

  typedef enum logic [1:0] {
    StLowStable,
    StWaitHigh,
    StHighStable,
    StWaitLow
  } deb_state_e;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a glitchy asynchronous input into a registered level with edge pulses
// and a saturating count of accepted rising edges.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SyncStagesDefault,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned CNT_WIDTH       = CntWidthDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 clr_count,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] rise_count,
  output logic                 cnt_sat
);

  localparam int unsigned StableW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [StableW-1:0]   StableLast = StableW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StableW-1:0]   StableOne  = StableW'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax     = '1;

  logic din_s;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (din_s)
  );

  deb_state_e         state_q, state_d;
  logic [StableW-1:0] stable_q, stable_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      StLowStable: begin
        if (din_s) begin
          state_d  = StWaitHigh;
          stable_d = StableOne;
        end
      end
      StWaitHigh: begin
        if (!din_s) begin
          state_d  = StLowStable;
          stable_d = '0;
        end else if (stable_q == StableLast) begin
          state_d  = StHighStable;
          stable_d = '0;
          level_d  = 1'b1;
          rise_d   = 1'b1;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      StHighStable: begin
        if (!din_s) begin
          state_d  = StWaitLow;
          stable_d = StableOne;
        end
      end
      StWaitLow: begin
        if (din_s) begin
          state_d  = StHighStable;
          stable_d = '0;
        end else if (stable_q == StableLast) begin
          state_d  = StLowStable;
          stable_d = '0;
          level_d  = 1'b0;
          fall_d   = 1'b1;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      default: begin
        state_d  = StLowStable;
        stable_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLowStable;
      stable_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;

  // Counts the registered rise pulse, so the count lags the pulse by one cycle.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_count) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (rise_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == (CntMax - 1'b1)) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign rise_count = cnt_q;
  assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a run-length reference model.
module tb_input_debouncer;

  localparam int SS   = 2;
  localparam int DC   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic          clr_count = 1'b0;
  logic          level, rise, fall, cnt_sat;
  logic [CW-1:0] rise_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: din delay line, and a run length of samples disagreeing with level.
  bit m_sync[SS];
  bit m_level, m_rise, m_fall, m_sat;
  int m_run, m_cnt;

  input_debouncer #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .clr_count (clr_count),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .rise_count(rise_count),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    bit ds, old_rise;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
      m_level = 0; m_rise = 0; m_fall = 0; m_sat = 0; m_run = 0; m_cnt = 0;
      return;
    end
    ds       = m_sync[SS-1];
    old_rise = m_rise;
    m_rise   = 0;
    m_fall   = 0;
    if (ds != m_level) begin
      m_run++;
      if (m_run == DC) begin
        m_level = ds;
        m_rise  = ds;
        m_fall  = !ds;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    if (clr_count) begin
      m_cnt = 0;
      m_sat = 0;
    end else if (old_rise) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt == CMAX) m_sat = 1;
    end
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = din;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", level, m_level);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("rise_count", rise_count, m_cnt);
    check("cnt_sat", cnt_sat, m_sat);
    check("rise_fall_excl", rise & fall, 1'b0);
  endtask

  // Edges from now until level reaches v, bounded.
  task automatic wait_level(input logic v, input string tag);
    int edges;
    edges = 0;
    do begin
      step();
      edges++;
    end while (level !== v && edges < 20);
    check(tag, edges, SS + DC);
  endtask

  initial begin
    int hold;
    // Reset with din low
    repeat (2) step();
    check("rst_level", level, 1'b0);
    check("rst_count", rise_count, 0);
    rst = 1'b0;
    step();

    // Clean rise and fall
    din = 1'b1;
    wait_level(1'b1, "rise_latency");
    check("rise_pulse", rise, 1'b1);
    step();
    check("count_after_rise", rise_count, 1);
    din = 1'b0;
    wait_level(1'b0, "fall_latency");
    check("fall_pulse", fall, 1'b1);

    // Short excursion is rejected
    rst = 1'b1; step(); rst = 1'b0;
    din = 1'b1; repeat (3) step();
    din = 1'b0; repeat (10) step();
    check("glitch_level", level, 1'b0);
    check("glitch_count", rise_count, 0);

    // Saturation at CNT_WIDTH=2, then clear
    for (int p = 1; p <= 5; p++) begin
      din = 1'b1; repeat (8) step();
      din = 1'b0; repeat (8) step();
      if (p == 3) begin
        check("sat_count3", rise_count, 3);
        check("sat_flag3", cnt_sat, 1'b1);
      end
    end
    check("sat_count5", rise_count, 3);
    clr_count = 1'b1; step(); clr_count = 1'b0;
    check("clr_count", rise_count, 0);
    check("clr_sat", cnt_sat, 1'b0);

    // Reset during qualification restarts from the synchronizer
    din = 1'b1; repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_level(1'b1, "requal_latency");

    // Clear coincident with rise loses that increment
    din = 1'b0;
    wait_level(1'b0, "fall_latency2");
    din = 1'b1;
    hold = 0;
    do begin step(); hold++; end while (rise !== 1'b1 && hold < 20);
    check("rise_seen", rise, 1'b1);
    clr_count = 1'b1; step(); clr_count = 1'b0;
    check("clr_rise_level", level, 1'b1);
    check("clr_rise_count", rise_count, 0);

    // Randomized run
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        din  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      clr_count = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
